// File: rtl/score_pkg.sv
// Shared types and glyph address helper for the score engine.
package score_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam bcd_t BCD_NINE = 4'h9;

  function automatic int glyph_addr(
    input bcd_t d,
    input int   row,
    input int   px,
    input int   gw,
    input int   gh
  );
    return int'(d) * gw * gh + row * gw + px;
  endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// One BCD digit add/subtract with carry/borrow in and out.
module bcd_digit_alu
  import score_pkg::*;
(
  input  logic sub,
  input  bcd_t d,
  input  bcd_t opnd,
  input  logic cin,
  output bcd_t q,
  output logic cout
);

  logic [4:0] s;
  logic [4:0] need;

  always_comb begin
    cout = 1'b0;
    need = {1'b0, opnd} + {4'b0, cin};
    if (!sub) begin
      s = {1'b0, d} + need;
      if (s > 5'd9) begin
        s    = s - 5'd10;
        cout = 1'b1;
      end
    end else if ({1'b0, d} < need) begin
      s    = {1'b0, d} + 5'd10 - need;
      cout = 1'b1;
    end else begin
      s = {1'b0, d} - need;
    end
    q = s[3:0];
  end

endmodule

// File: rtl/score_bcd_engine.sv
// BCD score keeper with serial digit FSM and HUD glyph renderer.
// Define SCORE_HISCORE_EN to build the high-score register.
module score_bcd_engine
  import score_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int GLYPH_W  = 60,
  parameter int GLYPH_H  = 80,
  parameter int X0       = 560,
  parameter int Y0       = 0,
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  input  logic                op_sub,
  input  logic [3:0]          op_amt,
  output logic                op_ready,
  output logic                gameover,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] hiscore_bcd,
  input  logic [11:0]         x_p,
  input  logic [11:0]         y_p,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic                rom_data,
  output logic                is_filled
);

  localparam int W  = 4 * DIGITS;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state;
  logic [W-1:0]    work;
  logic [W-1:0]    work_nxt;
  logic [W-1:0]    score_q;
  logic [W-1:0]    new_score;
  logic            sub_q;
  bcd_t            amt_q;
  logic            c_q;
  logic [KW-1:0]   k;
  logic            ready_q;
  logic            go_q;
  logic            new_go;
  logic            last;
  bcd_t            d_k;
  bcd_t            opnd;
  bcd_t            q_k;
  logic            cout;

  assign last = (k == KW'(DIGITS - 1));
  assign opnd = (k == '0) ? amt_q : '0;

  always_comb begin
    d_k      = '0;
    work_nxt = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (k == KW'(i)) begin
        d_k               = work[i*4 +: 4];
        work_nxt[i*4 +: 4] = q_k;
      end
    end
  end

  bcd_digit_alu u_alu (
    .sub  (sub_q),
    .d    (d_k),
    .opnd (opnd),
    .cin  (c_q),
    .q    (q_k),
    .cout (cout)
  );

  always_comb begin
    new_go    = 1'b0;
    new_score = work_nxt;
    if (!sub_q && cout) begin
      new_score = {DIGITS{BCD_NINE}};
    end else if (sub_q && (cout || work_nxt == '0)) begin
      new_score = '0;
      new_go    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      work    <= '0;
      score_q <= '0;
      sub_q   <= 1'b0;
      amt_q   <= '0;
      c_q     <= 1'b0;
      k       <= '0;
      ready_q <= 1'b1;
      go_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready_q <= !go_q;
          if (op_valid && ready_q) begin
            sub_q   <= op_sub;
            amt_q   <= (op_amt > 4'd9) ? BCD_NINE : op_amt;
            work    <= score_q;
            c_q     <= 1'b0;
            k       <= '0;
            ready_q <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          work <= work_nxt;
          c_q  <= cout;
          k    <= k + KW'(1);
          if (last) begin
            score_q <= new_score;
            go_q    <= go_q | new_go;
            ready_q <= !(go_q | new_go);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign op_ready  = ready_q;
  assign gameover  = go_q;
  assign score_bcd = score_q;

`ifdef SCORE_HISCORE_EN
  logic [W-1:0] hi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
    end else if (state == RUN && last && new_score > hi_q) begin
      hi_q <= new_score;
    end
  end

  assign hiscore_bcd = hi_q;
`else
  assign hiscore_bcd = '0;
`endif

  // Display works one pixel ahead so the ROM latency lines up.
  int   xi, yi, col, j, row, px;
  logic in_win, blank, flag_q;
  bcd_t dv;

  always_comb begin
    xi = int'(x_p) + 1;
    yi = int'(y_p);
    if (int'(x_p) >= SCREEN_W - 1) begin
      xi = 0;
      yi = (int'(y_p) >= SCREEN_H - 1) ? 0 : int'(y_p) + 1;
    end
    in_win = (xi >= X0) && (xi < X0 + DIGITS * GLYPH_W) &&
             (yi >= Y0) && (yi < Y0 + GLYPH_H);
    col   = in_win ? (xi - X0) / GLYPH_W : 0;
    j     = DIGITS - 1 - col;
    row   = yi - Y0;
    px    = xi - X0 - col * GLYPH_W;
    dv    = '0;
    blank = (j != 0);
    for (int i = 0; i < DIGITS; i++) begin
      if (i == j) dv = score_q[i*4 +: 4];
      if (i >= j && score_q[i*4 +: 4] != '0) blank = 1'b0;
    end
    rom_addr = in_win ?
      ADDR_W'(glyph_addr(dv, row, px, GLYPH_W, GLYPH_H)) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) flag_q <= 1'b0;
    else       flag_q <= in_win && !blank;
  end

  assign is_filled = flag_q & rom_data;

endmodule

// File: tb/tb_score_bcd_engine.sv
// Directed self-checking bench for score_bcd_engine.
module tb_score_bcd_engine;

  localparam int DIGITS = 4;
`ifdef SCORE_HISCORE_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_sub = 1'b0;
  logic [3:0]  op_amt = '0;
  logic        op_ready;
  logic        gameover;
  logic [15:0] score_bcd;
  logic [15:0] hiscore_bcd;
  logic [11:0] x_p = 12'd0;
  logic [11:0] y_p = 12'd300;
  logic [15:0] rom_addr;
  logic        rom_data = 1'b1;
  logic        is_filled;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_bcd_engine dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_sub      (op_sub),
    .op_amt      (op_amt),
    .op_ready    (op_ready),
    .gameover    (gameover),
    .score_bcd   (score_bcd),
    .hiscore_bcd (hiscore_bcd),
    .x_p         (x_p),
    .y_p         (y_p),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .is_filled   (is_filled)
  );

  function automatic logic [15:0] hx(input logic [15:0] v);
    return HI ? v : 16'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic s, input logic [3:0] a);
    int n;
    n = 0;
    while (op_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", {31'b0, op_ready}, 32'd1);
    op_valid = 1'b1;
    op_sub   = s;
    op_amt   = a;
    tick();
    op_valid = 1'b0;
    repeat (DIGITS) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_score", score_bcd, 0);
    check("rst_hi", hiscore_bcd, 0);
    check("rst_go", gameover, 0);
    check("rst_ready", op_ready, 1);
    check("rst_fill", is_filled, 0);

    // add 7 with op_valid held through the busy window
    op_valid = 1'b1;
    op_sub   = 1'b0;
    op_amt   = 4'd7;
    tick();
    check("busy0", op_ready, 0);
    for (int i = 1; i < DIGITS; i++) begin
      tick();
      check("busy", op_ready, 0);
    end
    tick();
    check("add7_ready", op_ready, 1);
    check("add7", score_bcd, 16'h0007);
    op_valid = 1'b0;
    repeat (3) tick();
    check("add7_once", score_bcd, 16'h0007);

    do_op(1'b0, 4'd5);
    check("add5", score_bcd, 16'h0012);
    check("hi12", hiscore_bcd, hx(16'h0012));

    for (int i = 0; i < 1111; i++) do_op(1'b0, 4'd9);
    check("nines", score_bcd, 16'h9999);
    do_op(1'b0, 4'd1);
    check("sat", score_bcd, 16'h9999);
    check("sat_go", gameover, 0);

    do_reset();
    do_op(1'b0, 4'd12);
    check("clamp", score_bcd, 16'h0009);
    do_op(1'b0, 4'd9);
    do_op(1'b0, 4'd9);
    do_op(1'b0, 4'd9);
    do_op(1'b0, 4'd6);
    check("s42", score_bcd, 16'h0042);
    do_op(1'b1, 4'd2);
    check("sub2", score_bcd, 16'h0040);
    check("hi42", hiscore_bcd, hx(16'h0042));
    check("sub2_go", gameover, 0);

    do_reset();
    do_op(1'b0, 4'd3);
    do_op(1'b1, 4'd3);
    check("zero", score_bcd, 0);
    check("go", gameover, 1);
    check("go_ready", op_ready, 0);
    check("go_hi", hiscore_bcd, hx(16'h0003));
    op_valid = 1'b1;
    op_sub   = 1'b0;
    op_amt   = 4'd5;
    repeat (10) tick();
    op_valid = 1'b0;
    check("go_blk", score_bcd, 0);
    check("go_stk", gameover, 1);

    do_reset();
    check("rst2_score", score_bcd, 0);
    check("rst2_hi", hiscore_bcd, 0);
    check("rst2_go", gameover, 0);
    check("rst2_ready", op_ready, 1);

    // display: score 7 on row 10
    do_op(1'b0, 4'd7);
    y_p      = 12'd10;
    x_p      = 12'd564;
    rom_data = 1'b1;
    #1;
    check("addr_d3", rom_addr, 605);
    tick();
    check("blank_d3", is_filled, 0);
    x_p = 12'd749;
    #1;
    check("addr_d0", rom_addr, 34210);
    tick();
    check("fill_hi", is_filled, 1);
    rom_data = 1'b0;
    #1;
    check("fill_lo", is_filled, 0);
    x_p = 12'd798;
    #1;
    check("addr_edge", rom_addr, 34259);
    x_p = 12'd799;
    y_p = 12'd9;
    #1;
    check("addr_wrap", rom_addr, 0);
    x_p = 12'd749;
    y_p = 12'd79;
    #1;
    check("addr_y79", rom_addr, 38350);
    y_p = 12'd80;
    #1;
    check("addr_y80", rom_addr, 0);
    x_p = 12'd100;
    y_p = 12'd10;
    #1;
    check("addr_out", rom_addr, 0);
    tick();
    rom_data = 1'b1;
    #1;
    check("fill_out", is_filled, 0);
    y_p = 12'd300;

    // reset mid-run
    do_reset();
    do_op(1'b0, 4'd8);
    check("s8", score_bcd, 16'h0008);
    op_valid = 1'b1;
    op_sub   = 1'b0;
    op_amt   = 4'd5;
    tick();
    op_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_score", score_bcd, 0);
    check("abort_ready", op_ready, 1);
    repeat (DIGITS + 1) tick();
    check("abort_late", score_bcd, 0);
    check("abort_go", gameover, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
